mmio_bus_ctrl: RTL and testbench

Parametrised memory-mapped bus controller between the multicycle processor and its peripherals. It decodes the upper address bits into a RAM region, NUM_OUT output-register regions and one input-port region. It generates RAM write strobes and sequences the RAM's one-cycle read latency with a ready/valid handshake. Output registers support write/set/clear/toggle modes, which generalises the single LED register.

---
 rtl/mmio_bus_ctrl_pkg.sv | 12 +
 rtl/mmio_out_reg.sv | 37 +++
 rtl/mmio_bus_ctrl.sv | 129 ++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared types for the memory-mapped bus controller: region decode,
// output-register write modes and controller FSM states.
package mmio_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_OUT, REG_IN, REG_NONE} region_e;

  // Output-register update mode, taken from the two low address bits
  typedef enum logic [1:0] {WM_WRITE, WM_SET, WM_CLR, WM_TGL} wmode_e;

  typedef enum logic {S_IDLE, S_RAM_WAIT} state_e;

endpackage

// File: rtl/mmio_out_reg.sv
// One memory-mapped output register with write/set/clear/toggle update.
module mmio_out_reg
  import mmio_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  wmode_e            mode_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      case (mode_i)
        WM_WRITE: q_d = wdata_i;
        WM_SET:   q_d = q_q | wdata_i;
        WM_CLR:   q_d = q_q & ~wdata_i;
        WM_TGL:   q_d = q_q ^ wdata_i;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: decodes RAM / output-register / input-port
// regions, sequences the one-cycle RAM read latency and flags bad accesses.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 9,
  parameter int SEL_W   = 2,
  parameter int RAM_AW  = 7,
  parameter int NUM_OUT = 2,
  parameter int IN_W    = 9
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  input  logic                      cpu_we,
  input  logic                      cpu_re,
  output logic                      cpu_ready,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_rvalid,
  output logic [RAM_AW-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wdata,
  output logic                      ram_we,
  input  logic [DATA_W-1:0]         ram_rdata,
  output logic [NUM_OUT*DATA_W-1:0] out_q,
  input  logic [IN_W-1:0]           in_data,
  output logic                      bus_err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, reg_rd;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [IN_W-1:0]   sync1_q, sync2_q;
  logic [SEL_W-1:0]  sel;
  region_e           region;
  logic              accept, wr_acc, rd_acc;
  logic [NUM_OUT-1:0] out_we;

  assign sel = cpu_addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    region = REG_NONE;
    if (sel == '0)                           region = REG_RAM;
    else if (sel <= SEL_W'(NUM_OUT))         region = REG_OUT;
    else if (sel == SEL_W'(NUM_OUT + 1))     region = REG_IN;
  end

  assign cpu_ready = (state_q == S_IDLE);
  assign accept    = (cpu_we | cpu_re) & cpu_ready;
  // A simultaneous read+write is executed as the write
  assign wr_acc    = accept & cpu_we;
  assign rd_acc    = accept & ~cpu_we;

  assign ram_addr  = cpu_addr[RAM_AW-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = wr_acc & (region == REG_RAM);

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_we[k] = wr_acc & (region == REG_OUT) & (sel == SEL_W'(k + 1));
    mmio_out_reg #(.DATA_W(DATA_W)) u_out (
      .clk    (clk),
      .reset  (reset),
      .we_i   (out_we[k]),
      .mode_i (wmode_e'(cpu_addr[1:0])),
      .wdata_i(cpu_wdata),
      .q_o    (out_q[k*DATA_W +: DATA_W])
    );
  end

  // Register-style read mux; unmapped selects fall through to zero
  always_comb begin
    reg_rd = '0;
    for (int k = 0; k < NUM_OUT; k++)
      if (sel == SEL_W'(k + 1)) reg_rd = out_q[k*DATA_W +: DATA_W];
    if (region == REG_IN) reg_rd = DATA_W'(sync2_q);
  end

  always_comb begin
    state_d  = state_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          if (region == REG_RAM) begin
            state_d = S_RAM_WAIT;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = reg_rd;
          end
        end
      end
      S_RAM_WAIT: begin
        state_d  = S_IDLE;
        rvalid_d = 1'b1;
        rdata_d  = ram_rdata;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept & ((cpu_we & cpu_re) | (cpu_we & (region == REG_IN)) | (region == REG_NONE)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      sync1_q  <= in_data;
      sync2_q  <= sync1_q;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model (memory array, register array, expected rvalid).
module tb_mmio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata, in_data;
  logic        cpu_we, cpu_re, cpu_ready, cpu_rvalid, ram_we, bus_err;
  logic [6:0]  ram_addr;
  logic [17:0] out_q;

  // Second instance with a single output register, leaving sel 3 unmapped
  logic [8:0]  c1_addr, c1_wdata, c1_rdata, c1_ram_wdata, c1_ram_rdata, c1_out;
  logic        c1_we, c1_re, c1_ready, c1_rvalid, c1_ram_we, c1_err;
  logic [6:0]  c1_ram_addr;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mmio_bus_ctrl #(.DATA_W(9), .ADDR_W(9), .SEL_W(2), .RAM_AW(7), .NUM_OUT(2), .IN_W(9)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .out_q(out_q), .in_data(in_data), .bus_err(bus_err));

  mmio_bus_ctrl #(.DATA_W(9), .ADDR_W(9), .SEL_W(2), .RAM_AW(7), .NUM_OUT(1), .IN_W(9)) dut1 (
    .clk(clk), .reset(reset), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_we(c1_we), .cpu_re(c1_re), .cpu_ready(c1_ready), .cpu_rdata(c1_rdata),
    .cpu_rvalid(c1_rvalid), .ram_addr(c1_ram_addr), .ram_wdata(c1_ram_wdata), .ram_we(c1_ram_we),
    .ram_rdata(c1_ram_rdata), .out_q(c1_out), .in_data(in_data), .bus_err(c1_err));

  // Synchronous RAM peripheral, cleared by reset
  logic [8:0] mem [128];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model state
  logic [8:0] ref_mem [128];
  logic [8:0] ref_out [2];
  logic       ref_err, exp_ready, exp_rvalid, ram_wait;
  logic [8:0] ref_in, exp_rdata;
  logic [6:0] pend_a;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    ref_out[0] = '0; ref_out[1] = '0;
    ref_err = 1'b0; exp_ready = 1'b1; exp_rvalid = 1'b0; exp_rdata = '0;
    ram_wait = 1'b0; ref_in = '0; pend_a = '0;
  endtask

  // Drives one bus cycle, checks every visible output, then advances the model
  task automatic bus_cycle(input logic we, input logic re, input logic [8:0] addr, input logic [8:0] wd);
    logic [1:0] sel;
    logic       acc;
    int         idx;
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
    sel = addr[8:7];
    acc = (we | re) & exp_ready;
    @(negedge clk);
    n_tot++; if (cpu_ready !== exp_ready) $display("FAIL ready: got %b exp %b t=%0t", cpu_ready, exp_ready, $time); else n_pass++;
    n_tot++; if (cpu_rvalid !== exp_rvalid) $display("FAIL rvalid: got %b exp %b t=%0t", cpu_rvalid, exp_rvalid, $time); else n_pass++;
    n_tot++; if (cpu_rdata !== exp_rdata) $display("FAIL rdata: got %h exp %h t=%0t", cpu_rdata, exp_rdata, $time); else n_pass++;
    n_tot++; if (out_q !== {ref_out[1], ref_out[0]}) $display("FAIL out_q: got %h exp %h t=%0t", out_q, {ref_out[1], ref_out[0]}, $time); else n_pass++;
    n_tot++; if (bus_err !== ref_err) $display("FAIL bus_err: got %b exp %b t=%0t", bus_err, ref_err, $time); else n_pass++;
    n_tot++; if (ram_we !== (acc & we & (sel == 2'd0))) $display("FAIL ram_we: got %b exp %b t=%0t", ram_we, acc & we & (sel == 2'd0), $time); else n_pass++;
    if (acc) begin
      n_tot++; if (ram_addr !== addr[6:0]) $display("FAIL ram_addr: got %h exp %h t=%0t", ram_addr, addr[6:0], $time); else n_pass++;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_re = 1'b0;
    exp_rvalid = 1'b0;
    if (ram_wait) begin
      exp_rdata = ref_mem[pend_a]; exp_rvalid = 1'b1; ram_wait = 1'b0; exp_ready = 1'b1;
    end else if (acc && we) begin
      if (re) ref_err = 1'b1;
      if (sel == 2'd0) ref_mem[addr[6:0]] = wd;
      else if (sel == 2'd3) ref_err = 1'b1;
      else begin
        idx = int'(sel) - 1;
        case (addr[1:0])
          2'd0: ref_out[idx] = wd;
          2'd1: ref_out[idx] = ref_out[idx] | wd;
          2'd2: ref_out[idx] = ref_out[idx] & ~wd;
          default: ref_out[idx] = ref_out[idx] ^ wd;
        endcase
      end
    end else if (acc) begin
      if (sel == 2'd0) begin
        ram_wait = 1'b1; exp_ready = 1'b0; pend_a = addr[6:0];
      end else begin
        exp_rvalid = 1'b1;
        exp_rdata  = (sel == 2'd3) ? ref_in : ref_out[int'(sel) - 1];
      end
    end
  endtask

  task automatic settle_input(input logic [8:0] v);
    in_data = v;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    ref_in = v;
  endtask

  task automatic test_reset();
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    n_tot++; if (out_q !== 18'h0 || cpu_ready !== 1'b1 || bus_err !== 1'b0 || cpu_rvalid !== 1'b0)
      $display("FAIL reset_state: got out=%h rdy=%b err=%b rv=%b", out_q, cpu_ready, bus_err, cpu_rvalid); else n_pass++;
  endtask

  task automatic test_ram();
    bus_cycle(1'b1, 1'b0, 9'h003, 9'h055);
    bus_cycle(1'b0, 1'b1, 9'h003, 9'h000);
    n_tot++; if (cpu_ready !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL ram_wait: got rdy=%b rv=%b exp 0 0", cpu_ready, cpu_rvalid); else n_pass++;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    n_tot++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 9'h055) $display("FAIL ram_read: got rv=%b rdata=%h exp 1 055", cpu_rvalid, cpu_rdata); else n_pass++;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
  endtask

  task automatic test_out_modes();
    logic [8:0] addrs [4];
    logic [8:0] wds [4];
    logic [8:0] exps [4];
    addrs = '{9'h080, 9'h081, 9'h082, 9'h083};
    wds   = '{9'h0F0, 9'h00F, 9'h030, 9'h101};
    exps  = '{9'h0F0, 9'h0FF, 9'h0CF, 9'h1CE};
    for (int i = 0; i < 4; i++) begin
      bus_cycle(1'b1, 1'b0, addrs[i], wds[i]);
      n_tot++; if (out_q[8:0] !== exps[i] || out_q[17:9] !== 9'h0)
        $display("FAIL out_mode%0d: got out0=%h out1=%h exp %h 000", i, out_q[8:0], out_q[17:9], exps[i]); else n_pass++;
    end
  endtask

  task automatic test_in_port();
    settle_input(9'h1A5);
    bus_cycle(1'b0, 1'b1, 9'h180, 9'h000);
    n_tot++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 9'h1A5 || cpu_ready !== 1'b1)
      $display("FAIL in_read: got rv=%b rdata=%h rdy=%b exp 1 1a5 1", cpu_rvalid, cpu_rdata, cpu_ready); else n_pass++;
    bus_cycle(1'b0, 1'b1, 9'h100, 9'h000);
    n_tot++; if (cpu_rdata !== 9'h000) $display("FAIL out1_read: got %h exp 000", cpu_rdata); else n_pass++;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
  endtask

  task automatic test_back_to_back();
    bus_cycle(1'b1, 1'b0, 9'h100, 9'h0AB);
    bus_cycle(1'b0, 1'b1, 9'h080, 9'h000);
    bus_cycle(1'b0, 1'b1, 9'h100, 9'h000);
    bus_cycle(1'b0, 1'b1, 9'h180, 9'h000);
    bus_cycle(1'b1, 1'b0, 9'h013, 9'h1C3);
    bus_cycle(1'b0, 1'b1, 9'h081, 9'h000);
    bus_cycle(1'b0, 1'b1, 9'h013, 9'h000);
    bus_cycle(1'b1, 1'b0, 9'h080, 9'h111);
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    n_tot++; if (cpu_rdata !== 9'h1C3 || out_q[8:0] === 9'h111) $display("FAIL b2b_ram: got rdata=%h out0=%h", cpu_rdata, out_q[8:0]); else n_pass++;
  endtask

  task automatic test_errors();
    bus_cycle(1'b1, 1'b1, 9'h080, 9'h0AA);
    n_tot++; if (bus_err !== 1'b1 || out_q[8:0] !== 9'h0AA) $display("FAIL we_re_err: got err=%b out0=%h exp 1 0aa", bus_err, out_q[8:0]); else n_pass++;
    bus_cycle(1'b1, 1'b0, 9'h180, 9'h077);
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    n_tot++; if (bus_err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", bus_err); else n_pass++;
  endtask

  task automatic test_unmapped_n1();
    c1_re = 1'b1; c1_addr = 9'h100;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    c1_re = 1'b0;
    n_tot++; if (c1_rvalid !== 1'b1 || c1_rdata !== in_data || c1_err !== 1'b0)
      $display("FAIL n1_in_read: got rv=%b rdata=%h err=%b exp 1 %h 0", c1_rvalid, c1_rdata, c1_err, in_data); else n_pass++;
    c1_re = 1'b1; c1_addr = 9'h180;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    c1_re = 1'b0;
    n_tot++; if (c1_rvalid !== 1'b1 || c1_rdata !== 9'h000 || c1_err !== 1'b1 || c1_ready !== 1'b1)
      $display("FAIL n1_unmapped: got rv=%b rdata=%h err=%b rdy=%b exp 1 000 1 1", c1_rvalid, c1_rdata, c1_err, c1_ready); else n_pass++;
    c1_we = 1'b1; c1_addr = 9'h180; c1_wdata = 9'h1FF;
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    c1_we = 1'b0;
    n_tot++; if (c1_out !== 9'h000 || c1_rvalid !== 1'b0) $display("FAIL n1_unmapped_wr: got out=%h rv=%b exp 000 0", c1_out, c1_rvalid); else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    bus_cycle(1'b1, 1'b0, 9'h081, 9'h03C);
    bus_cycle(1'b0, 1'b1, 9'h003, 9'h000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_tot++; if (cpu_rvalid !== 1'b0 || cpu_ready !== 1'b1 || out_q !== 18'h0 || bus_err !== 1'b0)
      $display("FAIL reset_in_wait: got rv=%b rdy=%b out=%h err=%b", cpu_rvalid, cpu_ready, out_q, bus_err); else n_pass++;
    settle_input(in_data);
  endtask

  task automatic test_random();
    int         k;
    logic       we, re;
    logic [8:0] a;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        settle_input(9'($urandom));
      end else begin
        k  = $urandom_range(0, 9);
        we = (k >= 1 && k <= 4) || k == 9;
        re = (k >= 5 && k <= 8) || k == 9;
        a  = {2'($urandom), 3'b000, 4'($urandom)};
        bus_cycle(we, re, a, 9'($urandom));
      end
    end
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
    bus_cycle(1'b0, 1'b0, 9'h000, 9'h000);
  endtask

  initial begin
    reset = 1'b1;
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0; in_data = '0;
    c1_we = 1'b0; c1_re = 1'b0; c1_addr = '0; c1_wdata = '0; c1_ram_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_ram();
    test_out_modes();
    test_in_port();
    test_back_to_back();
    test_unmapped_n1();
    test_errors();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
